// File: rtl/digit_serial_adder_pkg.sv
// Shared constants and helpers for the digit-serial adder.
// No logic: state encoding and a counter-width helper only.
// Not applicable: holds no state and exerts no backpressure.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter needs at least one bit even when a single digit covers the word.
    function automatic int cnt_bits(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Start/busy/done command bus between a controlling FSM and the adder.
// Latency is set by the adder: done arrives WIDTH/DIGIT+1 cycles after start.
// No backpressure: start is ignored while busy, results persist until the next done.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/digit_serial_adder_rca_digit.sv
// DIGIT-bit combinational ripple-carry chain of full adders.
// Zero cycles: purely combinational.
// No flow control.
module rca_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic c_v;

    // Carry walks as a scalar so the chain is not a self-referencing vector.
    always_comb begin
        s     = '0;
        c_v   = ci;
        c_msb = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb = c_v;
            s[i] = x[i] ^ y[i] ^ c_v;
            c_v  = (x[i] & y[i]) | (c_v & (x[i] ^ y[i]));
        end
        co = c_v;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Two's-complement WIDTH-bit adder processing DIGIT bits per clock through a registered carry.
// Latency: busy for WIDTH/DIGIT cycles after the accepting cycle, done pulse one cycle later.
// start is accepted only in IDLE or DONE; requests during RUN are dropped.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    digit_serial_adder_if.slave bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_bits(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cmsb;
    logic             accept;
    logic             last;

    assign accept = bus.start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);

    rca_digit #(.DIGIT(DIGIT)) u_rca (
        .x     (a_sh[DIGIT-1:0]),
        .y     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the top; after NDIG shifts the LSB digit has reached bit 0.
    assign acc_nxt = (acc >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                carry <= bus.cin;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                carry <= dig_co;
                acc   <= acc_nxt;
                cnt   <= cnt + CW'(1);
            end
            if (last) begin
                sum_q  <= acc_nxt;
                cout_q <= dig_co;
                ovf_q  <= dig_co ^ dig_cmsb;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, multi-cycle two's-complement adder. It adds two WIDTH-bit operands DIGIT bits per clock through a registered carry. It is the sequential, width-generic successor to the single-bit full adder and fixed ripple-carry adders in the arithmetic library. Area scales with DIGIT rather than WIDTH, for datapaths that trade latency for gate count. A start/busy/done handshake connects it to a controlling FSM.

## Interface
- WIDTH, 16, operand and sum width; must be a multiple of DIGIT
- DIGIT, 4, bits added per cycle (width of the ripple chain); 1 ≤ DIGIT ≤ WIDTH
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when idle-capable (IDLE or DONE)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while digits are being computed
- done  output  1  one-cycle pulse: result registers updated
- sum  output  WIDTH  result, held until next completion
- cout  output  1  unsigned carry-out of bit WIDTH-1
- overflow  output  1  signed overflow: carry into MSB XOR cout

## Operation
- NDIG = WIDTH/DIGIT digits; digit counter width max(1, clog2(NDIG)).
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1.
  - RUN→DONE after NDIG RUN cycles.
  - DONE→RUN on start=1; otherwise DONE→IDLE.
- Accepted start loads a and b into right-shift registers, cin into the carry register, and clears the counter.
- Each RUN cycle:
  - adds the low DIGIT bits of both shift registers plus the carry register;
  - shifts the DIGIT-bit digit sum into the top of the internal sum shift register;
  - shifts both operands right by DIGIT;
  - updates the carry register;
  - increments the counter.
- On the last RUN edge: sum, cout and overflow output registers load the final values. overflow uses the carry into bit WIDTH-1 taken from the last digit's chain.
- start while in RUN is ignored; operands are not re-sampled.
- Outputs never show partial sums; sum, cout and overflow change only on the edge entering DONE.
- busy = (state == RUN); done = (state == DONE).

## Timing
- rst_n low asynchronously forces IDLE and clears the counter, carry, shift registers, sum, cout, overflow, busy and done (all 0), regardless of state.
- Reset mid-RUN aborts the operation; no done is produced. The first start after rst_n rises behaves normally.
- Count the start-accepting cycle as cycle 0:
  - busy is high in cycles 1..NDIG;
  - done is high in cycle NDIG+1, with sum/cout/overflow valid from that cycle.
- WIDTH=16, DIGIT=4 gives done in cycle 5. DIGIT=WIDTH gives done in cycle 2.
- Back-to-back: start=1 in the DONE cycle is accepted, and busy is high the next cycle. Throughput is one result per NDIG+1 cycles.
- Results persist in IDLE indefinitely until the next completion or reset.

## Structure
- Shared arithmetic package holds the state encoding constants (IDLE, RUN, DONE).
- NDIG and the counter width are module-local derived parameters.
- One sub-module: rca_digit, a DIGIT-bit combinational ripple chain of full adders.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, and c_msb (the carry into its top bit).
- The top level holds the FSM, counter, shift registers, carry register and output registers.

## Test plan
- WIDTH=16/DIGIT=4: a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, overflow=0; done in cycle 5, busy in cycles 1–4.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, overflow=0. Repeat with DIGIT=16 → same result, done in cycle 2. Repeat with DIGIT=1 → done in cycle 17.
- start pulsed in cycle 2 with a=0x0001, b=0x0001 during an operation on 0x1234+0x4321 → ignored; result 0x5555. start held high in the DONE cycle with 0x0001+0x0002 → busy in the next cycle, sum=0x0003 five cycles later.
- rst_n low mid-cycle in cycle 3 of RUN → busy, done, sum, cout and overflow all 0 immediately, no done pulse. After release, 0x00FF+0x0001 → sum=0x0100.
- Idle check: start=0 for 20 cycles after a completion → done stays 0 and sum holds its value.
